// File: rtl/ysyx_24100005_pkg.sv
// rtl/ysyx_24100005_pkg.sv - shared funct3 codes, LSU state type and access-size helpers
package ysyx_24100005_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] lsu_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return 2'd0;
            F3_LH, F3_LHU: return 2'd1;
            F3_LW, F3_LWU: return 2'd2;
            default:       return 2'd3;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic wen, input logic [2:0] funct3, input logic is64);
        if (wen) begin
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW) ||
                   (is64 && (funct3 == F3_SD));
        end
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            F3_LD, F3_LWU:                        return is64;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// rtl/ysyx_24100005_lsu_align.sv - store lane/mask shifting and load extract/extend
module ysyx_24100005_lsu_align #(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic [1:0]        st_size,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [XLEN-1:0]   st_lane_wdata,
    output logic [STRB_W-1:0] st_wmask,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);
    import ysyx_24100005_pkg::*;

    logic [STRB_W-1:0] w_mask_base;
    logic [XLEN-1:0]   w_shifted;

    always_comb begin
        case (st_size)
            2'd0:    w_mask_base = STRB_W'(1);
            2'd1:    w_mask_base = STRB_W'(3);
            2'd2:    w_mask_base = STRB_W'(15);
            default: w_mask_base = '1;
        endcase
    end

    // Shifting within STRB_W/XLEN drops lanes past the word boundary.
    assign st_wmask      = w_mask_base << st_off;
    assign st_lane_wdata = st_wdata << {st_off, 3'b000};

    assign w_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_funct3)
            F3_LB:   ld_data = XLEN'(signed'(w_shifted[7:0]));
            F3_LH:   ld_data = XLEN'(signed'(w_shifted[15:0]));
            F3_LW:   ld_data = XLEN'(signed'(w_shifted[31:0]));
            F3_LBU:  ld_data = XLEN'(w_shifted[7:0]);
            F3_LHU:  ld_data = XLEN'(w_shifted[15:0]);
            F3_LWU:  ld_data = XLEN'(w_shifted[31:0]);
            default: ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - multi-cycle load/store unit; LSU_MISALIGN_CHECK_EN enables alignment faults
module ysyx_24100005_lsu #(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wmask,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    import ysyx_24100005_pkg::*;

    lsu_state_t        r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_req_valid;
    logic [XLEN-1:0]   r_mem_addr;
    logic              r_mem_wen;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [STRB_W-1:0] r_mem_wmask;
    logic [2:0]        r_ld_funct3;
    logic [OFF_W-1:0]  r_ld_off;

    logic [OFF_W-1:0]  w_req_off;
    logic [1:0]        w_req_size;
    logic              w_misaligned;
    logic              w_req_err;
    logic [XLEN-1:0]   w_st_wdata;
    logic [STRB_W-1:0] w_st_wmask;
    logic [XLEN-1:0]   w_ld_data;

    assign w_req_off  = req_addr[OFF_W-1:0];
    assign w_req_size = lsu_size(req_funct3);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misaligned = lsu_misaligned(w_req_size, 3'(w_req_off));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_req_err = !lsu_legal(req_wen, req_funct3, XLEN == 64) || w_misaligned;

    ysyx_24100005_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .st_size       (w_req_size),
        .st_off        (w_req_off),
        .st_wdata      (req_wdata),
        .st_lane_wdata (w_st_wdata),
        .st_wmask      (w_st_wmask),
        .ld_funct3     (r_ld_funct3),
        .ld_off        (r_ld_off),
        .ld_rdata      (mem_rdata),
        .ld_data       (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_err      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
            r_ld_funct3     <= '0;
            r_ld_off        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_ld_funct3 <= req_funct3;
                        r_ld_off    <= w_req_off;
                        if (w_req_err) begin
                            // Rejected accesses never reach the bus.
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state         <= REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wen       <= req_wen;
                            r_mem_wdata     <= req_wen ? w_st_wdata : '0;
                            r_mem_wmask     <= req_wen ? w_st_wmask : '0;
                        end
                    end
                end
                REQ: begin
                    // An ack coinciding with the handshake is deliberately not consumed.
                    if (mem_req_ready) begin
                        r_state         <= WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_mem_wen ? '0 : w_ld_data;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_mem_wen    <= 1'b0;
                        r_mem_wmask  <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// tb/tb_ysyx_24100005_lsu.sv - self-checking bench for ysyx_24100005_lsu (honours LSU_MISALIGN_CHECK_EN)
module tb_ysyx_24100005_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_24100005_lsu #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        int          rdy, ack, rsp;
        logic        err;
        logic [31:0] rdata, wdata;
        logic [3:0]  mask;
    } vec_t;

    typedef struct {
        logic        bus;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  mask;
        logic        wen, err, stable;
        int          lat;
    } obs_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int rdy, input int ack, input int rsp, input logic err,
                                input logic [31:0] rdata, input logic [31:0] wdata, input logic [3:0] mask);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
        v.rdy = rdy; v.ack = ack; v.rsp = rsp;
        v.err = err; v.rdata = rdata; v.wdata = wdata; v.mask = mask;
        vecs.push_back(v);
    endfunction

    // Byte-level reference: which lanes an access touches and how its value is rebuilt.
    function automatic void model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [31:0] wdata, output logic [3:0] mask);
        int n;
        int off;
        logic [31:0] v;
        n   = 1 << f3[1:0];
        off = int'(addr[1:0]);
        err = wen ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % n != 0) err = 1'b1;
`endif
        rdata = '0;
        wdata = wd << (8 * off);
        mask  = '0;
        v     = '0;
        if (!err) begin
            if (wen) begin
                for (int i = 0; i < n; i++) if (off + i < 4) mask[off + i] = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) if (off + i < 4) v[8*i +: 8] = rd[8*(off+i) +: 8];
                if (!f3[2] && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                rdata = v;
            end
        end
    endfunction

    task automatic txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int rdy, input int ack, input int rsp, input logic spur,
                       output obs_t o);
        int hold;
        int ackw;
        int cyc;
        o = '{default: 0};
        o.stable = 1'b1;
        if (req_ready !== 1'b1) o.stable = 1'b0;
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_wen = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        hold = 0;
        ackw = -1;
        for (cyc = 1; cyc < 200 && resp_valid !== 1'b1; cyc++) begin
            mem_req_ready = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
            if (req_ready !== 1'b0) o.stable = 1'b0;
            if (mem_req_valid === 1'b1) begin
                if (!o.bus) begin
                    o.bus = 1'b1; o.addr = mem_addr; o.wen = mem_wen;
                    o.wdata = mem_wdata; o.mask = mem_wmask;
                end else if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {o.addr, o.wen, o.wdata, o.mask}) begin
                    o.stable = 1'b0;
                end
                if (hold == rdy) begin
                    mem_req_ready = 1'b1;
                    ackw = 0;
                    if (spur) begin mem_ack = 1'b1; mem_rdata = ~rd; end
                end
                hold++;
            end else if (ackw >= 0) begin
                if (ackw == ack) begin mem_ack = 1'b1; mem_rdata = rd; ackw = -1; end
                else ackw++;
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_ack = 1'b0;
        o.lat = cyc; o.rdata = resp_rdata; o.err = resp_err;
        for (int i = 0; i < rsp; i++) begin
            if (resp_valid !== 1'b1 || resp_rdata !== o.rdata || resp_err !== o.err ||
                req_ready !== 1'b0 || mem_req_valid !== 1'b0) o.stable = 1'b0;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) o.stable = 1'b0;
    endtask

    task automatic judge(input string nm, input logic wen, input logic [31:0] addr,
                         input int rdy, input int ack, input obs_t o, input logic eerr,
                         input logic [31:0] erdata, input logic [31:0] ewdata, input logic [3:0] emask);
        chk({nm, " err"}, 64'(o.err), 64'(eerr));
        chk({nm, " rdata"}, 64'(o.rdata), 64'(eerr ? 32'h0 : erdata));
        chk({nm, " bus_used"}, 64'(o.bus), 64'(!eerr));
        chk({nm, " latency"}, 64'(o.lat), 64'(eerr ? 1 : 3 + rdy + ack));
        chk({nm, " stable"}, 64'(o.stable), 64'(1));
        if (!eerr) begin
            chk({nm, " mem_addr"}, 64'(o.addr), 64'(addr & 32'hFFFF_FFFC));
            chk({nm, " mem_wen"}, 64'(o.wen), 64'(wen));
            if (wen) begin
                chk({nm, " wdata"}, 64'(o.wdata), 64'(ewdata));
                chk({nm, " wmask"}, 64'(o.mask), 64'(emask));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        obs_t o;
        logic m_err;
        logic [31:0] m_rdata, m_wdata;
        logic [3:0] m_mask;
        logic ok;
        logic mis;

`ifdef LSU_MISALIGN_CHECK_EN
        mis = 1'b1;
`else
        mis = 1'b0;
`endif
        add(1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, 4'hF);
        add(0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0, 32'hFFFF_FF80, 32'h0, 4'h0);
        add(0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 1, 1, 1, 0, 32'h0000_0080, 32'h0, 4'h0);
        add(1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 0, 0, 0, 32'h0, 32'hABCD_0000, 4'hC);
        add(0, 3'd1, 32'h8000_0002, 32'h0, 32'hABCD_0000, 0, 2, 0, 0, 32'hFFFF_ABCD, 32'h0, 4'h0);
        add(0, 3'd2, 32'h8000_0001, 32'h0, 32'h1122_3344, 0, 0, 0, mis, 32'h0011_2233, 32'h0, 4'h0);
        add(1, 3'd0, 32'h8000_0003, 32'h0000_0012, 32'h0, 0, 0, 0, 0, 32'h0, 32'h1200_0000, 4'h8);
        add(1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 5, 2, 3, 0, 32'h0, 32'hCAFE_F00D, 4'hF);
        add(0, 3'd7, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0);
        add(1, 3'd3, 32'h8000_0000, 32'h1234_5678, 32'h0, 0, 0, 2, 1, 32'h0, 32'h0, 4'h0);
        add(0, 3'd3, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0);
        add(0, 3'd6, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0);
        add(0, 3'd5, 32'h8000_0000, 32'h0, 32'h1234_F00D, 0, 0, 0, 0, 32'h0000_F00D, 32'h0, 4'h0);
        add(1, 3'd1, 32'h8000_0003, 32'h0000_ABCD, 32'h0, 0, 0, 0, mis, 32'h0, 32'hCD00_0000, 4'h8);
        add(0, 3'd1, 32'h8000_0003, 32'h0, 32'hAB00_0000, 0, 0, 0, mis, 32'h0000_00AB, 32'h0, 4'h0);
        add(0, 3'd2, 32'h8000_0008, 32'h0, 32'h8000_0001, 2, 0, 3, 0, 32'h8000_0001, 32'h0, 4'h0);

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", 64'(req_ready), 64'(1));
        chk("reset resp_valid", 64'(resp_valid), 64'(0));
        chk("reset resp_rdata", 64'(resp_rdata), 64'(0));
        chk("reset resp_err", 64'(resp_err), 64'(0));
        chk("reset mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("reset mem_wen", 64'(mem_wen), 64'(0));
        chk("reset mem_wmask", 64'(mem_wmask), 64'(0));

        foreach (vecs[k]) begin
            txn(vecs[k].wen, vecs[k].f3, vecs[k].addr, vecs[k].wd, vecs[k].rd,
                vecs[k].rdy, vecs[k].ack, vecs[k].rsp, 1'b0, o);
            judge($sformatf("vec%0d", k), vecs[k].wen, vecs[k].addr, vecs[k].rdy, vecs[k].ack, o,
                  vecs[k].err, vecs[k].rdata, vecs[k].wdata, vecs[k].mask);
        end

        // Reset while waiting on the bus: the late ack must not produce a response.
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0020; mem_req_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_wait mem_req_valid low in WAIT", 64'(mem_req_valid), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("rst_wait idle with no response", 64'(ok), 64'(1));
        txn(0, 3'd2, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 0, 1, 1, 1'b0, o);
        judge("rst_wait next LW", 1'b0, 32'h8000_0024, 0, 1, o, 1'b0, 32'h0BAD_F00D, 32'h0, 4'h0);

        for (int t = 0; t < 150; t++) begin
            logic        wen;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd;
            int          rdy, ack, rsp;
            wen  = 1'($urandom);
            f3   = 3'($urandom);
            addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            wd   = $urandom;
            rd   = $urandom;
            rdy  = $urandom_range(0, 3);
            ack  = $urandom_range(0, 3);
            rsp  = $urandom_range(0, 2);
            model(wen, f3, addr, wd, rd, m_err, m_rdata, m_wdata, m_mask);
            txn(wen, f3, addr, wd, rd, rdy, ack, rsp, 1'($urandom), o);
            judge($sformatf("rnd%0d w%0d f%0d a%0h", t, wen, f3, addr), wen, addr, rdy, ack, o,
                  m_err, m_rdata, m_wdata, m_mask);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
